// File: rtl/ipsxe_floating_point_fl2fx_arb_v1_0_if.sv
// Bus bundle for the shared fl2fx arbiter: requester streams, converter port and result stream.
// master = arbiter side, slave = requesters/converter/downstream side.
interface ipsxe_floating_point_fl2fx_arb_v1_0_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned FLOAT_W = 32,
  parameter int unsigned FIXED_W = 32,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ*FLOAT_W-1:0] req_tdata;
  logic [NUM_REQ-1:0]         req_tvalid;
  logic [NUM_REQ-1:0]         req_tready;

  logic [FLOAT_W-1:0]         cvt_a_tdata;
  logic                       cvt_tvalid;
  logic [FIXED_W-1:0]         cvt_result_tdata;
  logic                       cvt_result_tvalid;
  logic                       cvt_invalid_op;
  logic                       cvt_overflow;

  logic [FIXED_W-1:0]         result_tdata;
  logic [ID_W+1:0]            result_tuser;
  logic                       result_tvalid;
  logic                       result_tready;

  modport master (
    input  req_tdata, req_tvalid,
    output req_tready,
    output cvt_a_tdata, cvt_tvalid,
    input  cvt_result_tdata, cvt_result_tvalid, cvt_invalid_op, cvt_overflow,
    output result_tdata, result_tuser, result_tvalid,
    input  result_tready
  );

  modport slave (
    output req_tdata, req_tvalid,
    input  req_tready,
    input  cvt_a_tdata, cvt_tvalid,
    output cvt_result_tdata, cvt_result_tvalid, cvt_invalid_op, cvt_overflow,
    input  result_tdata, result_tuser, result_tvalid,
    output result_tready
  );
endinterface

// File: rtl/ipsxe_floating_point_fl2fx_arb_v1_0.sv
// Round-robin front end sharing one fl2fx converter among NUM_REQ streams; results return
// in grant order through a credit-protected FIFO tagged {id, invalid_op, overflow}.
module ipsxe_floating_point_fl2fx_arb_v1_0 #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned FLOAT_EXP_BIT  = 8,
  parameter int unsigned FLOAT_FRAC_BIT = 24,
  parameter int unsigned FIXED_INT_BIT  = 31,
  parameter int unsigned FIXED_FRAC_BIT = 1,
  parameter int unsigned CVT_LATENCY    = 1,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic i_aclk,
  input  logic i_areset_n,
  input  logic i_aclken,
  ipsxe_floating_point_fl2fx_arb_v1_0_if.master bus,
  output logic o_busy,
  output logic o_seq_error
);
  localparam int unsigned FLOAT_W = FLOAT_EXP_BIT + FLOAT_FRAC_BIT;
  localparam int unsigned FIXED_W = FIXED_INT_BIT + FIXED_FRAC_BIT;
  localparam int unsigned ID_W    = $clog2(NUM_REQ);
  localparam int unsigned TAG_W   = ID_W + 2;
  localparam int unsigned ENTRY_W = FIXED_W + TAG_W;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]    rr_q, rr_d, grant_id, cvt_id_q;
  logic [NUM_REQ-1:0] grant;
  logic               grant_en, xfer, pop, wr, fifo_empty;
  logic [FLOAT_W-1:0] sel_data, cvt_data_q;
  logic               cvt_vld_q;
  logic [CNT_W-1:0]   credit_q, credit_d;
  logic [TAG_W:0]     dl_q [CVT_LATENCY];
  logic [TAG_W:0]     dl_head;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] last_q, head_mem, head_entry;
  logic [PTR_W:0]     wr_ptr_q, rd_ptr_q;
  logic               seq_q;

  // Credit counts every result not yet popped, so a grant always has a FIFO slot waiting.
  always_comb begin : arb
    logic [ID_W:0] idx;
    grant    = '0;
    grant_id = '0;
    sel_data = '0;
    idx      = '0;
    grant_en = i_aclken & i_areset_n & (credit_q < CNT_W'(FIFO_DEPTH));
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_q} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (grant_en && (grant == '0) && bus.req_tvalid[idx[ID_W-1:0]]) begin
        grant[idx[ID_W-1:0]] = 1'b1;
        grant_id             = idx[ID_W-1:0];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_data = bus.req_tdata[i*FLOAT_W +: FLOAT_W];
    end
  end

  assign xfer       = |grant;
  assign dl_head    = dl_q[CVT_LATENCY-1];
  assign wr         = bus.cvt_result_tvalid & dl_head[TAG_W];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign pop        = i_aclken & ~fifo_empty & bus.result_tready;

  always_comb begin
    rr_d = rr_q;
    if (xfer) rr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // A pop in the same cycle as a grant does not free that grant's slot early.
  always_comb begin
    credit_d = credit_q;
    unique case ({xfer, pop})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      rr_q       <= '0;
      credit_q   <= '0;
      cvt_vld_q  <= 1'b0;
      cvt_data_q <= '0;
      cvt_id_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_q     <= '0;
      seq_q      <= 1'b0;
      for (int unsigned i = 0; i < CVT_LATENCY; i++) dl_q[i] <= '0;
    end else if (i_aclken) begin
      rr_q      <= rr_d;
      credit_q  <= credit_d;
      cvt_vld_q <= xfer;
      if (xfer) begin
        cvt_data_q <= sel_data;
        cvt_id_q   <= grant_id;
      end
      // Flags are combinational on the converter input, so capture them in the issue cycle.
      dl_q[0] <= {cvt_vld_q, cvt_id_q, bus.cvt_invalid_op, bus.cvt_overflow};
      for (int unsigned i = 1; i < CVT_LATENCY; i++) dl_q[i] <= dl_q[i-1];
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= head_mem;
      end
      if (bus.cvt_result_tvalid && !dl_head[TAG_W]) seq_q <= 1'b1;
    end
  end

  always_ff @(posedge i_aclk) begin
    if (i_aclken && wr) mem_q[wr_ptr_q[PTR_W-1:0]] <= {bus.cvt_result_tdata, dl_head[TAG_W-1:0]};
  end

  assign head_mem   = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign head_entry = fifo_empty ? last_q : head_mem;

  assign bus.req_tready    = grant;
  assign bus.cvt_a_tdata   = cvt_data_q;
  assign bus.cvt_tvalid    = cvt_vld_q;
  assign bus.result_tdata  = head_entry[ENTRY_W-1 -: FIXED_W];
  assign bus.result_tuser  = head_entry[TAG_W-1:0];
  assign bus.result_tvalid = ~fifo_empty;
  assign o_busy            = (credit_q != '0);
  assign o_seq_error       = seq_q;
endmodule

// File: tb/tb_ipsxe_floating_point_fl2fx_arb_v1_0.sv
// Randomized bench: a functional fl2fx converter drives the DUT; a queue-based model predicts
// grants, result timing/order, credit and sticky sequence error.
module tb_ipsxe_floating_point_fl2fx_arb_v1_0;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic aclken;
  logic inject;
  logic busy, seq_error;

  always #5 clk = ~clk;

  ipsxe_floating_point_fl2fx_arb_v1_0_if #(.NUM_REQ(N), .FLOAT_W(32), .FIXED_W(32)) bus ();

  ipsxe_floating_point_fl2fx_arb_v1_0 #(
    .NUM_REQ(N), .FLOAT_EXP_BIT(8), .FLOAT_FRAC_BIT(24), .FIXED_INT_BIT(31),
    .FIXED_FRAC_BIT(1), .CVT_LATENCY(1), .FIFO_DEPTH(4)
  ) u_dut (
    .i_aclk      (clk),
    .i_areset_n  (rst_n),
    .i_aclken    (aclken),
    .bus         (bus),
    .o_busy      (busy),
    .o_seq_error (seq_error)
  );

  // float32 -> signed Q31.1, round half to even, saturating; returns {result, invalid, overflow}
  function automatic logic [33:0] fl2fx(input logic [31:0] b);
    logic        s, inv, ovf;
    int          e, sh, n;
    logic [63:0] mant, mag, rem, half;
    logic [31:0] r;
    s = b[31]; e = int'(b[30:23]); inv = 1'b0; ovf = 1'b0; r = '0; mag = '0;
    if (e == 255) begin
      inv = 1'b1;
      if (b[22:0] != 0) r = 32'h8000_0000;
      else begin ovf = 1'b1; r = s ? 32'h8000_0000 : 32'h7FFF_FFFF; end
    end else begin
      mant = (e == 0) ? {41'b0, b[22:0]} : {40'b0, 1'b1, b[22:0]};
      sh   = (e == 0) ? -148 : e - 149;
      if (sh >= 9) mag = 64'h1_0000_0000;
      else if (sh >= 0) mag = mant << sh;
      else begin
        n = -sh;
        if (n >= 26) mag = '0;
        else begin
          mag  = mant >> n;
          rem  = mant & ((64'd1 << n) - 64'd1);
          half = 64'd1 << (n - 1);
          if (rem > half || (rem == half && mag[0])) mag = mag + 64'd1;
        end
      end
      if (!s && mag > 64'h7FFF_FFFF) begin ovf = 1'b1; r = 32'h7FFF_FFFF; end
      else if (s && mag >= 64'h8000_0000) begin ovf = 1'b1; r = 32'h8000_0000; end
      else r = s ? 32'(64'd0 - mag) : mag[31:0];
    end
    return {r, inv, ovf};
  endfunction

  // Functional converter: flags combinational on its input, data/valid one cycle later.
  logic [33:0] cvt_comb;
  logic [31:0] cvt_res_q;
  logic        cvt_vld_q;
  assign cvt_comb              = fl2fx(bus.cvt_a_tdata);
  assign bus.cvt_invalid_op    = cvt_comb[1];
  assign bus.cvt_overflow      = cvt_comb[0];
  assign bus.cvt_result_tdata  = cvt_res_q;
  assign bus.cvt_result_tvalid = cvt_vld_q | inject;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cvt_vld_q <= 1'b0;
      cvt_res_q <= '0;
    end else if (aclken) begin
      cvt_vld_q <= bus.cvt_tvalid;
      cvt_res_q <= cvt_comb[33:2];
    end
  end

  typedef struct {
    logic [31:0] data;
    logic [1:0]  id;
    logic        inv;
    logic        ovf;
    int          ready;
  } exp_t;

  exp_t q[$];
  int   ptr, credit, ecyc;
  bit   x1, x2, seq_exp;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] gen_float();
    logic [31:0] r;
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) r = $urandom;
    else if (sel == 1) begin
      case ($urandom_range(0, 4))
        0:       r = 32'h7FC0_0000;
        1:       r = 32'h7F80_0000;
        2:       r = 32'hFF80_0000;
        3:       r = 32'hCE80_0000;
        default: r = 32'h0000_0000;
      endcase
    end else r = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 160)), 23'($urandom)};
    return r;
  endfunction

  function automatic logic [127:0] rand_data();
    logic [127:0] d;
    for (int i = 0; i < N; i++) d[i*32 +: 32] = gen_float();
    return d;
  endfunction

  function automatic logic [127:0] with_slot(input logic [127:0] d, input int idx,
                                             input logic [31:0] val);
    logic [127:0] r;
    r = d;
    r[idx*32 +: 32] = val;
    return r;
  endfunction

  task automatic model_clear();
    q.delete();
    ptr = 0; credit = 0; x1 = 1'b0; x2 = 1'b0; seq_exp = 1'b0;
  endtask

  // One clock cycle: drive, check combinational outputs against the model, then advance it.
  task automatic step(input logic [3:0] v, input logic [127:0] d, input logic rdy,
                      input logic en, input logic inj);
    int          gid;
    logic [3:0]  erdy;
    logic        etv;
    logic [33:0] cv;
    exp_t        e;
    bus.req_tvalid    = v;
    bus.req_tdata     = d;
    bus.result_tready = rdy;
    aclken            = en;
    inject            = inj;
    #1;
    gid  = -1;
    erdy = '0;
    if (en && credit < 4) begin
      for (int k = 0; k < N; k++) begin
        if (gid < 0 && v[(ptr + k) % N]) gid = (ptr + k) % N;
      end
    end
    if (gid >= 0) erdy[gid] = 1'b1;
    etv = (q.size() > 0) && (q[0].ready <= ecyc);
    check("tready", 64'(bus.req_tready), 64'(erdy));
    check("tvalid", 64'(bus.result_tvalid), 64'(etv));
    check("busy", 64'(busy), 64'(credit != 0));
    check("seq_error", 64'(seq_error), 64'(seq_exp));
    if (etv && rdy && en) begin
      check("tdata", 64'(bus.result_tdata), 64'(q[0].data));
      check("tuser", 64'(bus.result_tuser), 64'({q[0].id, q[0].inv, q[0].ovf}));
    end
    @(posedge clk);
    if (en) begin
      if (inj && !x2) seq_exp = 1'b1;
      if (etv && rdy) begin
        void'(q.pop_front());
        credit--;
      end
      if (gid >= 0) begin
        cv      = fl2fx(d[gid*32 +: 32]);
        e.data  = cv[33:2];
        e.id    = 2'(gid);
        e.inv   = cv[1];
        e.ovf   = cv[0];
        e.ready = ecyc + 3;
        q.push_back(e);
        credit++;
        ptr = (gid + 1) % N;
      end
      x2 = x1;
      x1 = (gid >= 0);
      ecyc++;
    end
    #1;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_tready"}, 64'(bus.req_tready), 64'd0);
    check({tag, "_tvalid"}, 64'(bus.result_tvalid), 64'd0);
    check({tag, "_tdata"}, 64'(bus.result_tdata), 64'd0);
    check({tag, "_tuser"}, 64'(bus.result_tuser), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_seq"}, 64'(seq_error), 64'd0);
    check({tag, "_cvt_tvalid"}, 64'(bus.cvt_tvalid), 64'd0);
    check({tag, "_cvt_tdata"}, 64'(bus.cvt_a_tdata), 64'd0);
  endtask

  task automatic mid_reset();
    bus.req_tvalid    = '0;
    bus.result_tready = 1'b0;
    inject            = 1'b0;
    rst_n             = 1'b0;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    rst_n = 1'b0; aclken = 1'b1; inject = 1'b0;
    bus.req_tvalid = '0; bus.req_tdata = '0; bus.result_tready = 1'b0;
    model_clear();
    ecyc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;

    // single 1.0 from requester 2
    step(4'b0100, with_slot(rand_data(), 2, 32'h3F80_0000), 1'b1, 1'b1, 1'b0);
    repeat (5) step(4'b0000, rand_data(), 1'b1, 1'b1, 1'b0);

    // all requesters streaming at full rate
    repeat (40) step(4'b1111, rand_data(), 1'b1, 1'b1, 1'b0);
    repeat (4) step(4'b0000, rand_data(), 1'b1, 1'b1, 1'b0);

    // downstream stalled: credit limit, then a single pop
    repeat (8) step(4'b1111, rand_data(), 1'b0, 1'b1, 1'b0);
    step(4'b1111, rand_data(), 1'b1, 1'b1, 1'b0);
    repeat (4) step(4'b1111, rand_data(), 1'b0, 1'b1, 1'b0);
    repeat (8) step(4'b0000, rand_data(), 1'b1, 1'b1, 1'b0);

    // special operands
    step(4'b1010, with_slot(with_slot(rand_data(), 1, 32'h7FC0_0000), 3, 32'h7F80_0000),
         1'b1, 1'b1, 1'b0);
    step(4'b1000, with_slot(rand_data(), 3, 32'h7F80_0000), 1'b1, 1'b1, 1'b0);
    step(4'b0001, with_slot(rand_data(), 0, 32'hCE80_0000), 1'b1, 1'b1, 1'b0);
    repeat (6) step(4'b0000, rand_data(), 1'b1, 1'b1, 1'b0);

    // clock enable held low mid-stream
    repeat (3) step(4'b1111, rand_data(), 1'b1, 1'b1, 1'b0);
    repeat (5) step(4'b1111, rand_data(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    repeat (10) step(4'b1111, rand_data(), 1'b1, 1'b1, 1'b0);

    // random traffic, backpressure and clock-enable gaps
    for (int i = 0; i < 1500; i++) begin
      step(4'($urandom), rand_data(), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) != 0), 1'b0);
    end
    repeat (8) step(4'b0000, rand_data(), 1'b1, 1'b1, 1'b0);

    // converter result with nothing issued
    step(4'b0000, rand_data(), 1'b1, 1'b1, 1'b1);
    repeat (4) step(4'b0000, rand_data(), 1'b1, 1'b1, 1'b0);

    // reset with results queued and in flight, then restart from requester 0
    repeat (5) step(4'b1111, rand_data(), 1'b0, 1'b1, 1'b0);
    mid_reset();
    repeat (10) step(4'b1111, rand_data(), 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 200 && (q.size() != 0 || credit != 0); i++) begin
      step(4'b0000, rand_data(), 1'b1, 1'b1, 1'b0);
    end
    check("drain_busy", 64'(busy), 64'd0);
    check("drain_tvalid", 64'(bus.result_tvalid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
